// File: rtl/red_mc_pkg.sv
// red_mc_pkg: shared state encoding and fixed widths for the multi-cycle RED operation
package red_mc_pkg;
  localparam int OP_W    = 16;
  localparam int SLICE_W = 4;
  localparam int RED_LAT = 8;
  typedef enum logic [3:0] {IDLE, UL, UH, LL, LH, F0, F1, F2, DONE} state_t;
endpackage

// File: rtl/red_mc_cla_4bit.sv
// cla_4bit: 4-bit carry-lookahead add/sub slice with optional unsigned saturation
module cla_4bit
  import red_mc_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  logic               sub,
  input  logic               sat,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  logic [SLICE_W-1:0] bb, g, p, raw;
  logic [SLICE_W:0]   c;
  always_comb begin
    bb   = b ^ {SLICE_W{sub}};
    g    = a & bb;
    p    = a ^ bb;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    raw  = p ^ c[SLICE_W-1:0];
    cout = c[4];
    // saturation clamps to all-ones on add overflow and to zero on subtract borrow
    sum  = !sat ? raw : sub ? (c[4] ? raw : '0) : (c[4] ? '1 : raw);
  end
endmodule

// File: rtl/red_mc.sv
// red_mc: byte-reduction sum over one shared 4-bit slice in seven cycles (abort port under RED_MC_ABORT_EN)
module red_mc
  import red_mc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W-1:0] A,
  input  logic [OP_W-1:0] B,
`ifdef RED_MC_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic [OP_W-1:0] Out
);
  state_t state;
  logic [OP_W-1:0] op_a, op_b;
  logic [8:0] u, l;
  logic [7:0] f;
  logic carry, cin, cout, f12;
  logic [SLICE_W-1:0] sa, sb, sum;
  cla_4bit slice (.a(sa), .b(sb), .cin(cin), .sub(1'b0), .sat(1'b0), .sum(sum), .cout(cout));
  // final nibble adds the sign extensions of u and l, so f[12] is the 13-bit signed sum's sign
  assign f12 = u[8] ^ l[8] ^ cout;
  always_comb begin
    sa  = '0;
    sb  = '0;
    cin = carry;
    case (state)
      UL: begin sa = op_a[11:8];  sb = op_b[11:8];  cin = 1'b0; end
      UH: begin sa = op_a[15:12]; sb = op_b[15:12]; end
      LL: begin sa = op_a[3:0];   sb = op_b[3:0];   cin = 1'b0; end
      LH: begin sa = op_a[7:4];   sb = op_b[7:4];   end
      F0: begin sa = u[3:0];      sb = l[3:0];      cin = 1'b0; end
      F1: begin sa = u[7:4];      sb = l[7:4];      end
      F2: begin sa = {4{u[8]}};   sb = {4{l[8]}};   end
      default: cin = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Out   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      u     <= '0;
      l     <= '0;
      f     <= '0;
    end
`ifdef RED_MC_ABORT_EN
    else if (abort && busy) begin
      state <= IDLE;
      busy  <= 1'b0;
    end
`endif
    else begin
      case (state)
        UL: begin u[3:0] <= sum;         carry <= cout; state <= UH; end
        UH: begin u[8:4] <= {cout, sum}; carry <= cout; state <= LL; end
        LL: begin l[3:0] <= sum;         carry <= cout; state <= LH; end
        LH: begin l[8:4] <= {cout, sum}; carry <= cout; state <= F0; end
        F0: begin f[3:0] <= sum;         carry <= cout; state <= F1; end
        F1: begin f[7:4] <= sum;         carry <= cout; state <= F2; end
        F2: begin
          Out   <= {{3{f12}}, f12, sum, f};
          carry <= cout;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= A;
            op_b  <= B;
            carry <= 1'b0;
            busy  <= 1'b1;
            state <= UL;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_red_mc.sv
// tb_red_mc: randomized and directed checks of red_mc against a signed byte-sum model
module tb_red_mc;
  logic clk = 1'b0;
  logic rst, start, abort;
  logic [15:0] A, B, Out;
  logic busy, done;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  red_mc dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
`ifdef RED_MC_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .Out(Out)
  );

  // Out = signed(hi bytes sum as 9-bit) + signed(lo bytes sum as 9-bit), sign-extended
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    int hi, lo;
    hi = int'(a[15:8]) + int'(b[15:8]);
    lo = int'(a[7:0]) + int'(b[7:0]);
    if (hi >= 256) hi -= 512;
    if (lo >= 256) lo -= 512;
    return 16'(hi + lo);
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; A = 16'hFFFF; B = 16'hFFFF;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || Out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b Out=%h, want 0 0 0000", busy, done, Out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_compute;
    logic [15:0] va [4] = '{16'h0102, 16'hFFFF, 16'h8080, 16'h7F7F};
    logic [15:0] vb [4] = '{16'h0304, 16'hFFFF, 16'h8080, 16'h0101};
    logic [15:0] ve [4] = '{16'h000A, 16'hFFFC, 16'hFE00, 16'h0100};
    logic [15:0] a, b, exp;
    for (int i = 0; i < 40; i++) begin
      a = (i < 4) ? va[i] : 16'($urandom);
      b = (i < 4) ? vb[i] : 16'($urandom);
      exp = (i < 4) ? ve[i] : model(a, b);
      A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 7; c++) begin
        n_chk++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_window op%0d cyc%0d: busy=%b done=%b, want 1 0", i, c, busy, done);
        end
        A = 16'($urandom); B = 16'($urandom);
        start = (i >= 4 && c < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
      n_chk++;
      if (done !== 1'b1 || busy !== 1'b0 || Out !== exp) begin
        n_fail++;
        $display("FAIL result op%0d a=%h b=%h: done=%b busy=%b Out=%h, want done=1 busy=0 Out=%h", i, a, b, done, busy, Out, exp);
      end
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0 || Out !== exp) begin
        n_fail++;
        $display("FAIL done_pulse op%0d: done=%b busy=%b Out=%h, want 0 0 %h", i, done, busy, Out, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 7; c++) begin
      A = 16'($urandom); B = 16'($urandom);
      @(negedge clk);
    end
    n_chk++;
    if (done !== 1'b1 || Out !== model(a, b)) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b Out=%h, want 1 %h", done, Out, model(a, b));
    end
    A = 16'h0001; B = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      n_chk++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_busy cyc%0d: busy=%b done=%b, want 1 0", c, busy, done);
      end
      A = 16'($urandom); B = 16'($urandom);
      @(negedge clk);
    end
    n_chk++;
    if (done !== 1'b1 || Out !== 16'h0002) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b Out=%h, want 1 0002", done, Out);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    A = 16'h1234; B = 16'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || Out !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b done=%b Out=%h, want 0 0 0000", busy, done, Out);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_done cyc%0d: done=%b busy=%b, want 0 0", c, done, busy);
      end
    end
  endtask

  task automatic test_rst_start;
    rst = 1'b1; start = 1'b1; A = 16'h0102; B = 16'h0304;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_start: busy=%b, want 0", busy);
    end
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_start_after: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

`ifdef RED_MC_ABORT_EN
  task automatic test_abort;
    A = 16'h0102; B = 16'h0304; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    A = 16'h0001; B = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || Out !== 16'h000A) begin
      n_fail++;
      $display("FAIL abort_f1: busy=%b done=%b Out=%h, want 0 0 000A", busy, done, Out);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || Out !== 16'h000A) begin
        n_fail++;
        $display("FAIL abort_no_done cyc%0d: done=%b Out=%h, want 0 000A", c, done, Out);
      end
    end
    abort = 1'b1; start = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle_start: busy=%b, want 1", busy);
    end
    repeat (7) @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || Out !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL abort_idle_result: done=%b Out=%h, want 1 FFFC", done, Out);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_compute;
    test_back_to_back;
    test_rst_mid;
    test_rst_start;
`ifdef RED_MC_ABORT_EN
    test_abort;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
